video_output_sequencer: RTL

Controller that brings up and supervises the HDMI output timing generator. It watches the input video mode (line-doubled 240p vs. 480p, interlaced vs. progressive) once per input frame and debounces mode changes. It then holds the generator in reset while the buffer is flushed, waits until the line buffer holds enough lines, and only then issues the start trigger. It sits between the input capture logic and the output generator, driving that generator's `reset`, `starttrigger`, `line_doubler` and `add_line` inputs.

---
 rtl/video_output_sequencer_if.sv | 27 ++
 rtl/video_output_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/video_output_sequencer_if.sv
// Capture-side status in, output-generator control out, for the video output sequencer.
// Latency: none, this is only a signal bundle.
// Backpressure: none, all signals are single-cycle pulses or levels.
interface video_output_sequencer_if;
  logic       in_vsync;
  logic       in_line_done;
  logic       in_line_doubler;
  logic       in_interlaced;
  logic       gen_reset_n;
  logic       starttrigger;
  logic       line_doubler;
  logic       add_line;
  logic       running;
  logic [7:0] resync_count;

  // Sequencer side
  modport master (
    input  in_vsync, in_line_done, in_line_doubler, in_interlaced,
    output gen_reset_n, starttrigger, line_doubler, add_line, running, resync_count
  );

  // Capture logic / generator side
  modport slave (
    output in_vsync, in_line_done, in_line_doubler, in_interlaced,
    input  gen_reset_n, starttrigger, line_doubler, add_line, running, resync_count
  );
endinterface

// File: rtl/video_output_sequencer.sv
// Debounces the input video mode, flushes and pre-fills, then starts the HDMI generator.
// Latency: every output is registered, 1 cycle after the qualifying input cycle.
// Backpressure: none; pulses are consumed in the cycle they arrive.
module video_output_sequencer #(
  parameter int STABLE_FRAMES = 3,
  parameter int FLUSH_CYCLES  = 4,
  parameter int FILL_LINES    = 2,
  parameter int TIMEOUT       = 2_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  video_output_sequencer_if.master bus
);
  localparam logic [15:0] STABLE_W = 16'(STABLE_FRAMES);
  localparam logic [15:0] FLUSH_W  = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0] FILL_W   = 16'(FILL_LINES);
  localparam logic [23:0] WD_LAST  = 24'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_STABLE, FLUSH, FILL, RUN} state_t;

  state_t      state, state_n;
  logic [1:0]  candidate, candidate_n;
  logic [15:0] stable_cnt, stable_n;
  logic [15:0] flush_cnt, flush_n;
  logic [15:0] line_cnt, line_n;
  logic        armed, armed_n;
  logic [23:0] wd_cnt, wd_n;
  logic [1:0]  accepted, accepted_n;
  logic [7:0]  resync, resync_n;
  logic        gen_reset_n_q, starttrigger_q, running_q;

  logic [1:0] mode;
  logic       do_accept;
  logic       wd_expire;

  assign mode = {bus.in_line_doubler, bus.in_interlaced};

  // Register all state, counters and outputs; outputs are decoded from the next state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      candidate      <= 2'b00;
      stable_cnt     <= 16'd0;
      flush_cnt      <= 16'd0;
      line_cnt       <= 16'd0;
      armed          <= 1'b0;
      wd_cnt         <= 24'd0;
      accepted       <= 2'b00;
      resync         <= 8'd0;
      gen_reset_n_q  <= 1'b0;
      starttrigger_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state          <= state_n;
      candidate      <= candidate_n;
      stable_cnt     <= stable_n;
      flush_cnt      <= flush_n;
      line_cnt       <= line_n;
      armed          <= armed_n;
      wd_cnt         <= wd_n;
      accepted       <= accepted_n;
      resync         <= resync_n;
      gen_reset_n_q  <= (state_n == FILL) || (state_n == RUN);
      starttrigger_q <= (state_n == RUN);
      running_q      <= (state_n == RUN);
    end
  end

  // Next-state logic: mode debounce, flush timing, fill counting and the watchdog.
  always_comb begin
    state_n     = state;
    candidate_n = candidate;
    stable_n    = stable_cnt;
    flush_n     = flush_cnt;
    line_n      = line_cnt;
    armed_n     = armed;
    accepted_n  = accepted;
    resync_n    = resync;
    do_accept   = 1'b0;

    // The watchdog only runs outside IDLE; a vsync in the expiry cycle wins.
    wd_n      = (state == IDLE || bus.in_vsync) ? 24'd0 : wd_cnt + 24'd1;
    wd_expire = (state != IDLE) && !bus.in_vsync && (wd_cnt == WD_LAST);

    case (state)
      IDLE: begin
        if (bus.in_vsync) begin
          candidate_n = mode;
          stable_n    = 16'd1;
          state_n     = WAIT_STABLE;
          do_accept   = (STABLE_FRAMES <= 1);
        end
      end
      WAIT_STABLE: begin
        if (bus.in_vsync) begin
          stable_n    = (mode == candidate) ? stable_cnt + 16'd1 : 16'd1;
          candidate_n = mode;
          do_accept   = (stable_n >= STABLE_W);
        end
      end
      FLUSH: begin
        if (flush_cnt >= FLUSH_W) begin
          state_n = FILL;
          armed_n = 1'b0;
          line_n  = 16'd0;
        end else begin
          flush_n = flush_cnt + 16'd1;
        end
      end
      FILL, RUN: begin
        if (bus.in_vsync && mode != accepted) begin
          // Mode moved under us: restart debounce with this frame as the first match.
          candidate_n = mode;
          stable_n    = 16'd1;
          state_n     = WAIT_STABLE;
          do_accept   = (STABLE_FRAMES <= 1);
          if (resync != 8'hFF) resync_n = resync + 8'd1;
        end else if (state == FILL) begin
          if (bus.in_vsync) begin
            armed_n = 1'b1;
            line_n  = 16'd0;
          end else if (bus.in_line_done && armed) begin
            line_n = line_cnt + 16'd1;
            if (line_n >= FILL_W) state_n = RUN;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_accept) begin
      accepted_n = mode;
      state_n    = FLUSH;
      flush_n    = 16'd0;
    end

    if (wd_expire) begin
      state_n = IDLE;
      if (state == RUN && resync != 8'hFF) resync_n = resync + 8'd1;
    end
  end

  assign bus.gen_reset_n  = gen_reset_n_q;
  assign bus.starttrigger = starttrigger_q;
  assign bus.running      = running_q;
  assign bus.line_doubler = accepted[1];
  assign bus.add_line     = accepted[0];
  assign bus.resync_count = resync;
endmodule
